actor_responder: RTL

ACTOR_RESPONDER -- requirements
Module: actor_responder

---
 rtl/actor_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/actor_responder.sv
// Dataflow actor invocation wrapper: one FIFO-to-FIFO action, fired
// up to MAX_FIRINGS times per ap_start with a fixed execute latency.
module actor_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_FIRINGS  = 4,
  parameter int EXEC_LATENCY = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic [1:0]            ap_return,
  input  logic                  actor_enable,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty_n,
  output logic                  in_read,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full_n,
  output logic                  out_write,
  output logic [15:0]           fire_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [1:0] RET_IDLE = 2'd0;
  localparam logic [1:0] RET_WAIT = 2'd1;
  localparam logic [1:0] RET_TEST = 2'd2;
  localparam logic [1:0] RET_EXEC = 2'd3;

  localparam logic [7:0] MAX_F = 8'(MAX_FIRINGS);
  localparam logic [3:0] LAT_INIT = 4'(EXEC_LATENCY - 1);

  state_t                state;
  state_t                state_nx;
  logic                  en_q;
  logic [7:0]            firings;
  logic [3:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] token;
  logic [15:0]           fire_cnt;
  logic [1:0]            ret_q;
  logic [1:0]            ret_nx;
  logic                  ret_ld;
  logic                  rd;
  logic                  wr;

  always_comb begin
    state_nx = state;
    ret_nx   = ret_q;
    ret_ld   = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ap_start) state_nx = S_EVAL;
      end
      S_EVAL: begin
        if (!en_q) begin
          state_nx = S_DONE;
          ret_ld   = 1'b1;
          ret_nx   = RET_IDLE;
        end else if (firings == MAX_F) begin
          state_nx = S_DONE;
          ret_ld   = 1'b1;
          ret_nx   = RET_EXEC;
        end else if (in_empty_n && out_full_n) begin
          rd       = 1'b1;
          state_nx = S_EXEC;
        end else begin
          state_nx = S_DONE;
          ret_ld   = 1'b1;
          if (firings != 8'd0)
            ret_nx = RET_EXEC;
          else if (!in_empty_n)
            ret_nx = RET_WAIT;
          else
            ret_nx = RET_TEST;
        end
      end
      // Sole writer of the output FIFO: space seen in S_EVAL still holds.
      S_EXEC: begin
        if (lat_cnt == 4'd0) begin
          wr       = 1'b1;
          state_nx = S_EVAL;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      en_q     <= 1'b0;
      firings  <= 8'd0;
      lat_cnt  <= 4'd0;
      token    <= '0;
      fire_cnt <= 16'd0;
      ret_q    <= RET_IDLE;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && ap_start) begin
        en_q    <= actor_enable;
        firings <= 8'd0;
      end
      if (rd) begin
        token   <= in_dout;
        lat_cnt <= LAT_INIT;
      end else if (state == S_EXEC && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (wr) begin
        firings  <= firings + 8'd1;
        fire_cnt <= fire_cnt + 16'd1;
      end
      if (ret_ld) ret_q <= ret_nx;
    end
  end

  // FIFO strobes are masked during reset so an abandoned firing never lands.
  assign in_read    = rd & ap_rst_n;
  assign out_write  = wr & ap_rst_n;
  assign out_din    = out_write ? token + DATA_WIDTH'(1) : '0;
  assign ap_done    = (state == S_DONE);
  assign ap_ready   = ap_done;
  assign ap_idle    = (state == S_IDLE);
  assign ap_return  = ret_q;
  assign fire_count = fire_cnt;

endmodule
